// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module : core_pkg
// Shared pipeline constants: result selects, forwarding selects, hazard FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  localparam logic [2:0] RES_ALU   = 3'd0;
  localparam logic [2:0] RES_LOAD  = 3'd1;
  localparam logic [2:0] RES_PC4   = 3'd2;
  localparam logic [2:0] RES_IMM   = 3'd3;
  localparam logic [2:0] RES_AUIPC = 3'd4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MISS       = 2'd1,
    ST_MISS_REDIR = 2'd2
  } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module : hazard_ctrl_if
// Pipeline-side signal bundle between the core datapath and hazard_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D, rs2D;
  logic [4:0]       rs1E, rs2E, rdE;
  logic [2:0]       resultsrcE;
  logic             pcsrcE;
  logic [XLEN-1:0]  pctargetE;
  logic [4:0]       rdM;
  logic             regwriteM;
  logic [4:0]       rdW;
  logic             regwriteW;
  logic             icache_ready;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD;
  logic             flushD, flushE;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] miss_cycles;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, resultsrcE, pcsrcE, pctargetE,
           rdM, regwriteM, rdW, regwriteW, icache_ready,
    input  forwardAE, forwardBE, stallF, stallD, flushD, flushE,
           redirect_valid, redirect_pc, miss_cycles
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, resultsrcE, pcsrcE, pctargetE,
           rdM, regwriteM, rdW, regwriteW, icache_ready,
    output forwardAE, forwardBE, stallF, stallD, flushD, flushE,
           redirect_valid, redirect_pc, miss_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
// ============================================================================
// Module : fwd_unit
// Single-operand EX forwarding select; MEM result wins over WB result.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fwd_unit
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdM,
  input  logic       regwriteM,
  input  logic [4:0] rdW,
  input  logic       regwriteW,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_REG;
    if (regwriteW && (rdW != 5'd0) && (rdW == rs)) fwd = FWD_WB;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs)) fwd = FWD_MEM;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Forwarding, load-use stall, and I-cache miss / deferred-redirect sequencing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  hz_state_t        state;
  logic [XLEN-1:0]  saved_pc;
  logic [CNT_W-1:0] miss_cnt;
  logic             lw_stall;
  logic             stall_f, stall_d, flush_d, flush_e, redir_valid;

  fwd_unit u_fwd_a (
    .rs(hz.rs1E), .rdM(hz.rdM), .regwriteM(hz.regwriteM),
    .rdW(hz.rdW), .regwriteW(hz.regwriteW), .fwd(hz.forwardAE)
  );

  fwd_unit u_fwd_b (
    .rs(hz.rs2E), .rdM(hz.rdM), .regwriteM(hz.regwriteM),
    .rdW(hz.rdW), .regwriteW(hz.regwriteW), .fwd(hz.forwardBE)
  );

  assign lw_stall = (hz.resultsrcE == RES_LOAD) && (hz.rdE != 5'd0) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  always_comb begin
    stall_f     = lw_stall;
    stall_d     = lw_stall;
    flush_d     = 1'b0;
    flush_e     = lw_stall;
    redir_valid = 1'b0;
    case (state)
      ST_RUN: begin
        if (!hz.icache_ready) begin
          stall_f = 1'b1;
          flush_d = !lw_stall;
        end
        if (hz.pcsrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      ST_MISS: begin
        // A redirect arriving with the fill makes the fetched word wrong-path.
        if (!hz.icache_ready || hz.pcsrcE) begin
          stall_f = 1'b1;
          flush_d = !lw_stall;
        end
        if (hz.pcsrcE) flush_e = 1'b1;
      end
      ST_MISS_REDIR: begin
        flush_d     = 1'b1;
        stall_f     = !hz.icache_ready;
        redir_valid = hz.icache_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      saved_pc <= '0;
      miss_cnt <= '0;
    end else begin
      if (state != ST_RUN) miss_cnt <= miss_cnt + CNT_W'(1);
      case (state)
        ST_RUN: begin
          if (!hz.icache_ready) begin
            if (hz.pcsrcE) begin
              saved_pc <= hz.pctargetE;
              state    <= ST_MISS_REDIR;
            end else begin
              state    <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (hz.pcsrcE) begin
            saved_pc <= hz.pctargetE;
            state    <= ST_MISS_REDIR;
          end else if (hz.icache_ready) begin
            state    <= ST_RUN;
          end
        end
        ST_MISS_REDIR: begin
          if (hz.icache_ready) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign hz.stallF         = stall_f;
  assign hz.stallD         = stall_d;
  assign hz.flushD         = flush_d;
  assign hz.flushE         = flush_e;
  assign hz.redirect_valid = redir_valid;
  assign hz.redirect_pc    = saved_pc;
  assign hz.miss_cycles    = miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Directed plus randomized bench for hazard_ctrl against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(32), .CNT_W(32)) hz ();
  hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));

  int passed = 0;
  int total  = 0;

  // Model state: fetch blocked by a miss, and whether a redirect is waiting on it.
  bit          m_miss;
  bit          m_pend;
  logic [31:0] m_target;
  logic [31:0] m_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz.regwriteM && hz.rdM != 0 && hz.rdM == rs) return 2'b10;
    if (hz.regwriteW && hz.rdW != 0 && hz.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare all outputs against the model, then advance one clock.
  task automatic step();
    bit lw, rdy, br;
    bit e_sf, e_sd, e_fd, e_fe, e_rv;
    #2;
    lw  = (hz.resultsrcE == RES_LOAD) && hz.rdE != 0 &&
          (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
    rdy = hz.icache_ready;
    br  = hz.pcsrcE;
    e_sd = lw;
    e_rv = 1'b0;
    if (!m_miss) begin
      e_sf = lw || !rdy;
      e_fd = !lw && (!rdy || br);
      e_fe = lw || br;
    end else if (!m_pend) begin
      e_sf = lw || !rdy || br;
      e_fd = !lw && (!rdy || br);
      e_fe = lw || br;
    end else begin
      e_sf = !rdy;
      e_fd = 1'b1;
      e_fe = lw;
      e_rv = rdy;
    end
    check("forwardAE", 64'(hz.forwardAE), 64'(ref_fwd(hz.rs1E)));
    check("forwardBE", 64'(hz.forwardBE), 64'(ref_fwd(hz.rs2E)));
    check("stallF", 64'(hz.stallF), 64'(e_sf));
    check("stallD", 64'(hz.stallD), 64'(e_sd));
    check("flushD", 64'(hz.flushD), 64'(e_fd));
    check("flushE", 64'(hz.flushE), 64'(e_fe));
    check("redirect_valid", 64'(hz.redirect_valid), 64'(e_rv));
    check("redirect_pc", 64'(hz.redirect_pc), 64'(m_target));
    check("miss_cycles", 64'(hz.miss_cycles), 64'(m_count));
    if (rst) begin
      m_miss = 0; m_pend = 0; m_target = '0; m_count = '0;
    end else begin
      if (m_miss) m_count = m_count + 1;
      if (!m_miss) begin
        if (!rdy) begin
          m_miss = 1;
          if (br) begin m_pend = 1; m_target = hz.pctargetE; end
        end
      end else if (!m_pend) begin
        if (br) begin m_pend = 1; m_target = hz.pctargetE; end
        else if (rdy) m_miss = 0;
      end else if (rdy) begin
        m_miss = 0; m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.rs1D = 0; hz.rs2D = 0; hz.rs1E = 0; hz.rs2E = 0; hz.rdE = 0;
    hz.resultsrcE = RES_ALU; hz.pcsrcE = 0; hz.pctargetE = '0;
    hz.rdM = 0; hz.regwriteM = 0; hz.rdW = 0; hz.regwriteW = 0;
    hz.icache_ready = 1;
  endtask

  task automatic randomize_inputs();
    hz.rs1D = 5'($urandom_range(0, 7)); hz.rs2D = 5'($urandom_range(0, 7));
    hz.rs1E = 5'($urandom_range(0, 7)); hz.rs2E = 5'($urandom_range(0, 7));
    hz.rdE  = 5'($urandom_range(0, 7));
    hz.rdM  = 5'($urandom_range(0, 7)); hz.regwriteM = 1'($urandom);
    hz.rdW  = 5'($urandom_range(0, 7)); hz.regwriteW = 1'($urandom);
    hz.pcsrcE = ($urandom_range(0, 99) < 15);
    hz.pctargetE = $urandom;
    hz.resultsrcE = 3'($urandom_range(0, 4));
    if (hz.pcsrcE && hz.resultsrcE == RES_LOAD) hz.resultsrcE = RES_ALU;
    hz.icache_ready = ($urandom_range(0, 99) < 65);
    rst = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    m_miss = 0; m_pend = 0; m_target = '0; m_count = '0;
    idle();
    rst = 1;
    @(posedge clk); #1;
    step();
    rst = 0;

    // Reset state with idle inputs.
    step();

    // M-over-W forwarding, then W only, then x0.
    hz.rs1E = 5; hz.rdM = 5; hz.regwriteM = 1; hz.rdW = 5; hz.regwriteW = 1;
    #2; check("fwd_m_over_w", 64'(hz.forwardAE), 64'(2'b10));
    step();
    hz.regwriteM = 0;
    #2; check("fwd_w_only", 64'(hz.forwardAE), 64'(2'b01));
    step();
    hz.rdM = 0; hz.rdW = 0; hz.regwriteM = 1;
    #2; check("fwd_x0", 64'(hz.forwardAE), 64'(2'b00));
    step();
    idle();

    // Load-use on rs2, then rdE = x0.
    hz.resultsrcE = RES_LOAD; hz.rdE = 7; hz.rs2D = 7;
    #2; check("lw_stall", 64'({hz.stallF, hz.stallD, hz.flushE}), 64'(3'b111));
    step();
    hz.rdE = 0;
    #2; check("lw_x0", 64'({hz.stallF, hz.stallD, hz.flushE}), 64'(3'b000));
    step();
    idle();

    // Miss of four cycles without redirect.
    hz.icache_ready = 0;
    repeat (4) step();
    hz.icache_ready = 1;
    #2; check("miss_release", 64'({hz.stallF, hz.flushD}), 64'(2'b00));
    step();
    check("miss_cycles_4", 64'(hz.miss_cycles), 64'(4));
    step();

    // Redirect during miss.
    hz.icache_ready = 0;
    step();
    hz.pcsrcE = 1; hz.pctargetE = 32'h0000_0100;
    step();
    hz.pcsrcE = 0; hz.pctargetE = '0;
    step();
    hz.icache_ready = 1;
    #2; check("deferred_redirect", 64'({hz.redirect_valid, hz.flushD, hz.stallF}), 64'(3'b110));
    check("redirect_pc_100", 64'(hz.redirect_pc), 64'(32'h100));
    step();
    check("redirect_one_cycle", 64'(hz.redirect_valid), 64'(0));
    step();

    // Same-cycle miss and redirect, then reset while the redirect is pending.
    hz.icache_ready = 0; hz.pcsrcE = 1; hz.pctargetE = 32'h0000_2468;
    step();
    hz.pcsrcE = 0;
    check("same_cycle_capture", 64'(hz.redirect_pc), 64'(32'h2468));
    step();
    rst = 1;
    step();
    rst = 0; hz.icache_ready = 1;
    check("rst_no_redirect", 64'(hz.redirect_valid), 64'(0));
    check("rst_miss_cycles", 64'(hz.miss_cycles), 64'(0));
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end
    rst = 0;
    idle();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
